// File: rtl/io_write_queue.sv
// rtl/io_write_queue.sv - posted I/O write queue between the core memory port and the RAM/UART bus
//
// Ports:
//   clk_in, rst_in   clock, synchronous active-high reset
//   rdy_in           global enable; block frozen and core stalled when low
//   cpu_req/cpu_a/cpu_dout/cpu_wr   core bus request (address, write byte, write strobe)
//   cpu_stall        access not accepted this cycle; core holds and retries
//   mem_a/mem_dout/mem_wr           external bus (combinational mux of core and queue head)
//   io_buffer_full   UART cannot take a byte this cycle
//   q_count          number of queued I/O writes (0..DEPTH)
module io_write_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             cpu_req,
  input  logic [31:0]      cpu_a,
  input  logic [7:0]       cpu_dout,
  input  logic             cpu_wr,
  output logic             cpu_stall,
  output logic [31:0]      mem_a,
  output logic [7:0]       mem_dout,
  output logic             mem_wr,
  input  logic             io_buffer_full,
  output logic [PTR_W:0]   q_count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  // Each entry holds {addr[17:0], data[7:0]}.
  logic [25:0]      entry_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic is_io, ram_acc, io_wr, io_rd;
  logic q_empty, q_full;
  logic pass, want_enq, drain, enq;
  logic [25:0] head_entry;

  assign is_io      = (cpu_a[17:16] == 2'b11);
  assign ram_acc    = cpu_req & ~is_io;
  assign io_wr      = cpu_req & is_io & cpu_wr;
  assign io_rd      = cpu_req & is_io & ~cpu_wr;
  assign q_empty    = (count_q == '0);
  assign q_full     = (count_q == FULL_CNT);
  assign head_entry = entry_q[head_q];
  assign q_count    = count_q;

  always_comb begin
    mem_a     = cpu_req ? cpu_a : 32'd0;
    mem_dout  = 8'd0;
    mem_wr    = 1'b0;
    cpu_stall = 1'b0;
    pass      = 1'b0;
    want_enq  = 1'b0;
    drain     = 1'b0;
    enq       = 1'b0;

    if (ram_acc) begin
      mem_dout = cpu_dout;
      mem_wr   = cpu_wr;
      pass     = 1'b1;
    end else if (io_rd) begin
      // Reads may not overtake posted writes.
      if (q_empty) begin
        mem_dout = cpu_dout;
        pass     = 1'b1;
      end else begin
        cpu_stall = 1'b1;
      end
    end else if (io_wr) begin
      if (q_empty && !io_buffer_full) begin
        mem_dout = cpu_dout;
        mem_wr   = 1'b1;
        pass     = 1'b1;
      end else begin
        want_enq = 1'b1;
      end
    end

    // Any cycle the core does not own the bus can drain the head entry.
    if (!pass && !q_empty && !io_buffer_full) begin
      drain    = 1'b1;
      mem_a    = {14'd0, head_entry[25:8]};
      mem_dout = head_entry[7:0];
      mem_wr   = 1'b1;
    end

    // Fullness is judged after this cycle's drain, so a full queue that
    // drains can still take the new write.
    if (want_enq) begin
      if (!q_full || drain) enq = 1'b1;
      else                  cpu_stall = 1'b1;
    end

    if (!rdy_in) begin
      mem_wr    = 1'b0;
      cpu_stall = 1'b1;
      drain     = 1'b0;
      enq       = 1'b0;
    end

    if (rst_in) begin
      mem_wr = 1'b0;
      drain  = 1'b0;
      enq    = 1'b0;
    end
  end

  always_comb begin
    head_d  = drain ? head_q + 1'b1 : head_q;
    tail_d  = enq ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    if (enq && !drain)      count_d = count_q + 1'b1;
    else if (drain && !enq) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read when count_q says valid.
  always_ff @(posedge clk_in) begin
    if (enq) entry_q[tail_q] <= {cpu_a[17:0], cpu_dout};
  end

endmodule

// File: tb/tb_io_write_queue.sv
// tb/tb_io_write_queue.sv - self-checking bench for io_write_queue
module tb_io_write_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b1;
  logic             rdy_in = 1'b1;
  logic             cpu_req = 1'b0;
  logic [31:0]      cpu_a = 32'd0;
  logic [7:0]       cpu_dout = 8'd0;
  logic             cpu_wr = 1'b0;
  logic             cpu_stall;
  logic [31:0]      mem_a;
  logic [7:0]       mem_dout;
  logic             mem_wr;
  logic             io_buffer_full = 1'b0;
  logic [PTR_W:0]   q_count;

  int checks = 0;
  int errors = 0;

  io_write_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .cpu_req(cpu_req), .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr),
    .cpu_stall(cpu_stall), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .q_count(q_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic set_in(input logic req, input logic [31:0] a, input logic [7:0] d,
                        input logic wr, input logic iobf);
    cpu_req = req; cpu_a = a; cpu_dout = d; cpu_wr = wr; io_buffer_full = iobf;
  endtask

  task automatic settle;
    @(negedge clk_in);
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset;
    rst_in = 1'b1; rdy_in = 1'b1;
    set_in(1'b0, 32'd0, 8'd0, 1'b0, 1'b0);
    tick; tick;
    rst_in = 1'b0;
    settle;
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL reset_qcount got %0d want 0", q_count); end
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_memwr got %0b want 0", mem_wr); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", cpu_stall); end
    checks++; if (mem_a !== 32'd0) begin errors++; $display("FAIL reset_mema got %h want 0", mem_a); end
    tick;
    set_in(1'b1, 32'h00100, 8'd0, 1'b0, 1'b0);
    settle;
    checks++; if (mem_a !== 32'h00100) begin errors++; $display("FAIL reset_ramread_a got %h want 00100", mem_a); end
    tick;
  endtask

  task automatic test_passthrough;
    set_in(1'b1, 32'h30000, 8'h41, 1'b1, 1'b0);
    settle;
    checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL pass_wr got %0b want 1", mem_wr); end
    checks++; if (mem_a !== 32'h30000) begin errors++; $display("FAIL pass_a got %h want 30000", mem_a); end
    checks++; if (mem_dout !== 8'h41) begin errors++; $display("FAIL pass_dout got %h want 41", mem_dout); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL pass_stall got %0b want 0", cpu_stall); end
    tick;
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL pass_qcount got %0d want 0", q_count); end
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 32'h30000, 8'(8'h41 + i), 1'b1, 1'b1);
      settle;
      checks++;
      if (cpu_stall !== (i == 4)) begin errors++; $display("FAIL fill_stall[%0d] got %0b want %0b", i, cpu_stall, (i == 4)); end
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL fill_wr[%0d] got %0b want 0", i, mem_wr); end
      tick;
      checks++;
      if (q_count !== 3'((i < 4) ? i + 1 : 4)) begin errors++; $display("FAIL fill_qcount[%0d] got %0d", i, q_count); end
    end
    set_in(1'b0, 32'd0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      settle;
      checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL drain_wr[%0d] got %0b want 1", i, mem_wr); end
      checks++; if (mem_a !== 32'h30000) begin errors++; $display("FAIL drain_a[%0d] got %h want 30000", i, mem_a); end
      checks++; if (mem_dout !== 8'(8'h41 + i)) begin errors++; $display("FAIL drain_dout[%0d] got %h want %h", i, mem_dout, 8'(8'h41 + i)); end
      tick;
    end
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL drain_qcount got %0d want 0", q_count); end
    set_in(1'b1, 32'h30000, 8'h45, 1'b1, 1'b0);
    settle;
    checks++; if (cpu_stall !== 1'b0 || mem_wr !== 1'b1 || mem_dout !== 8'h45) begin
      errors++; $display("FAIL fifth_accept got stall=%0b wr=%0b dout=%h want 0 1 45", cpu_stall, mem_wr, mem_dout); end
    tick;
  endtask

  task automatic test_ram_priority;
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 32'h30000, 8'(8'h50 + i), 1'b1, 1'b1);
      tick;
    end
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'h00100, 8'd0, 1'b0, 1'b0);
      settle;
      checks++; if (mem_a !== 32'h00100 || mem_wr !== 1'b0 || cpu_stall !== 1'b0) begin
        errors++; $display("FAIL ram_pass[%0d] got a=%h wr=%0b stall=%0b want 00100 0 0", i, mem_a, mem_wr, cpu_stall); end
      tick;
      checks++; if (q_count !== 3'd2) begin errors++; $display("FAIL ram_qcount[%0d] got %0d want 2", i, q_count); end
    end
    set_in(1'b0, 32'd0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      settle;
      checks++; if (mem_wr !== 1'b1 || mem_dout !== 8'(8'h50 + i)) begin
        errors++; $display("FAIL ram_drain[%0d] got wr=%0b dout=%h want 1 %h", i, mem_wr, mem_dout, 8'(8'h50 + i)); end
      tick;
    end
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL ram_drain_qcount got %0d want 0", q_count); end
  endtask

  task automatic test_io_read_order;
    set_in(1'b1, 32'h30000, 8'h60, 1'b1, 1'b1);
    tick;
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 32'h30004, 8'd0, 1'b0, 1'b1);
      settle;
      checks++; if (cpu_stall !== 1'b1 || mem_wr !== 1'b0) begin
        errors++; $display("FAIL rd_blocked[%0d] got stall=%0b wr=%0b want 1 0", i, cpu_stall, mem_wr); end
      tick;
    end
    set_in(1'b1, 32'h30004, 8'd0, 1'b0, 1'b0);
    settle;
    checks++; if (cpu_stall !== 1'b1 || mem_wr !== 1'b1 || mem_dout !== 8'h60) begin
      errors++; $display("FAIL rd_drain got stall=%0b wr=%0b dout=%h want 1 1 60", cpu_stall, mem_wr, mem_dout); end
    tick;
    settle;
    checks++; if (cpu_stall !== 1'b0 || mem_wr !== 1'b0 || mem_a !== 32'h30004) begin
      errors++; $display("FAIL rd_pass got stall=%0b wr=%0b a=%h want 0 0 30004", cpu_stall, mem_wr, mem_a); end
    tick;
  endtask

  task automatic test_full_simultaneous;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'h30000 | 32'(i), 8'(8'h70 + i), 1'b1, 1'b1);
      tick;
    end
    checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL full_qcount got %0d want 4", q_count); end
    set_in(1'b1, 32'h30004, 8'h46, 1'b1, 1'b0);
    settle;
    checks++; if (cpu_stall !== 1'b0 || mem_wr !== 1'b1 || mem_dout !== 8'h70 || mem_a !== 32'h30000) begin
      errors++; $display("FAIL full_simul got stall=%0b wr=%0b a=%h dout=%h want 0 1 30000 70", cpu_stall, mem_wr, mem_a, mem_dout); end
    tick;
    checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL full_simul_qcount got %0d want 4", q_count); end
    set_in(1'b0, 32'd0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ea;
      logic [7:0]  ed;
      ea = (i < 3) ? (32'h30000 | 32'(i + 1)) : 32'h30004;
      ed = (i < 3) ? 8'(8'h71 + i) : 8'h46;
      settle;
      checks++; if (mem_wr !== 1'b1 || mem_a !== ea || mem_dout !== ed) begin
        errors++; $display("FAIL wrap_drain[%0d] got wr=%0b a=%h dout=%h want 1 %h %h", i, mem_wr, mem_a, mem_dout, ea, ed); end
      tick;
    end
  endtask

  task automatic test_rdy_reset;
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 32'h30000, 8'(8'h80 + i), 1'b1, 1'b1);
      tick;
    end
    set_in(1'b0, 32'd0, 8'd0, 1'b0, 1'b0);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle;
      checks++; if (mem_wr !== 1'b0 || cpu_stall !== 1'b1) begin
        errors++; $display("FAIL rdy_frozen[%0d] got wr=%0b stall=%0b want 0 1", i, mem_wr, cpu_stall); end
      tick;
      checks++; if (q_count !== 3'd2) begin errors++; $display("FAIL rdy_qcount[%0d] got %0d want 2", i, q_count); end
    end
    rdy_in = 1'b1;
    set_in(1'b1, 32'h30000, 8'h82, 1'b1, 1'b1);
    tick;
    checks++; if (q_count !== 3'd3) begin errors++; $display("FAIL pre_rst_qcount got %0d want 3", q_count); end
    set_in(1'b0, 32'd0, 8'd0, 1'b0, 1'b0);
    rst_in = 1'b1;
    settle;
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL rst_nowrite got %0b want 0", mem_wr); end
    tick;
    rst_in = 1'b0;
    settle;
    checks++; if (q_count !== 3'd0 || mem_wr !== 1'b0) begin
      errors++; $display("FAIL post_rst got q=%0d wr=%0b want 0 0", q_count, mem_wr); end
    tick;
  endtask

  task automatic test_random;
    logic [25:0] mq[$];
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic        req, wr, iobf, rdy, rst;
      logic [31:0] a;
      logic [7:0]  d;
      logic        is_io, pass, want, drain, accept, chk_a, chk_d;
      logic        e_stall, e_wr;
      logic [31:0] e_a;
      logic [7:0]  e_d;
      int          n;
      req  = ($urandom_range(0, 3) != 0);
      wr   = $urandom_range(0, 1);
      iobf = ($urandom_range(0, 2) == 0);
      rdy  = ($urandom_range(0, 15) != 0);
      rst  = ($urandom_range(0, 79) == 0);
      d    = 8'($urandom);
      if ($urandom_range(0, 2) != 0) a = {14'($urandom), 2'b11, 16'($urandom_range(0, 7))};
      else                           a = {14'($urandom), 18'($urandom % 32'h30000)};
      rst_in = rst; rdy_in = rdy;
      set_in(req, a, d, wr, iobf);

      is_io = (a[17:16] == 2'b11);
      n = mq.size();
      pass = 0; want = 0; drain = 0; accept = 0; chk_a = 0; chk_d = 0;
      e_stall = 0; e_wr = 0; e_a = 32'd0; e_d = 8'd0;
      if (req && !is_io) begin
        e_a = a; e_d = d; e_wr = wr; pass = 1; chk_a = 1; chk_d = 1;
      end else if (req && is_io && !wr) begin
        if (n == 0) begin pass = 1; e_a = a; chk_a = 1; end
        else e_stall = 1;
      end else if (req && is_io && wr) begin
        if (n == 0 && !iobf) begin pass = 1; e_a = a; e_d = d; e_wr = 1; chk_a = 1; chk_d = 1; end
        else want = 1;
      end else begin
        chk_a = 1; chk_d = 1;
      end
      if (!pass && n > 0 && !iobf) begin
        drain = 1; e_wr = 1; chk_a = 1; chk_d = 1;
        e_a = {14'd0, mq[0][25:8]}; e_d = mq[0][7:0];
      end
      if (want) begin
        if (n - int'(drain) < DEPTH) accept = 1;
        else e_stall = 1;
      end
      if (!rdy) begin e_wr = 0; e_stall = 1; chk_a = 0; chk_d = 0; drain = 0; accept = 0; end

      settle;
      if (rst) begin
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL rnd_rst_wr cyc=%0d got %0b want 0", cyc, mem_wr); end
      end else begin
        checks++; if (mem_wr !== e_wr) begin errors++; $display("FAIL rnd_wr cyc=%0d got %0b want %0b", cyc, mem_wr, e_wr); end
        checks++; if (cpu_stall !== e_stall) begin errors++; $display("FAIL rnd_stall cyc=%0d got %0b want %0b", cyc, cpu_stall, e_stall); end
        if (chk_a) begin
          checks++; if (mem_a !== e_a) begin errors++; $display("FAIL rnd_a cyc=%0d got %h want %h", cyc, mem_a, e_a); end
        end
        if (chk_d) begin
          checks++; if (mem_dout !== e_d) begin errors++; $display("FAIL rnd_dout cyc=%0d got %h want %h", cyc, mem_dout, e_d); end
        end
      end
      tick;
      if (rst) mq.delete();
      else begin
        if (drain) void'(mq.pop_front());
        if (accept) mq.push_back({a[17:0], d});
      end
      checks++; if (q_count !== 3'(mq.size())) begin errors++; $display("FAIL rnd_qcount cyc=%0d got %0d want %0d", cyc, q_count, mq.size()); end
    end
    rst_in = 1'b0; rdy_in = 1'b1;
    set_in(1'b0, 32'd0, 8'd0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_passthrough;
    test_fill_drain;
    test_ram_priority;
    test_io_read_order;
    test_full_simultaneous;
    test_rdy_reset;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_write_queue.md
Name: io_write_queue

Overview:
- Sits between the cpu core's byte-wide memory port and the external RAM/UART bus.
- Absorbs memory-mapped I/O writes (addr[17:16]==2'b11) into a small FIFO while the UART reports io_buffer_full, so the core does not have to stall on every UART byte.
- RAM traffic passes straight through.
- I/O ordering is preserved: queued I/O writes drain in order, and no I/O read is issued while writes are pending.

Parameters:
- DEPTH, 4, number of queued I/O write entries (power of two, >=2).
- PTR_W, 2, log2(DEPTH).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, synchronous, active-high
- rdy_in  input  1  global enable; block frozen when low
- cpu_req  input  1  core presents a bus access this cycle
- cpu_a  input  32  core address (only 17:0 decoded)
- cpu_dout  input  8  core write byte
- cpu_wr  input  1  1=write, 0=read
- cpu_stall  output  1  access not accepted this cycle; core must hold and retry
- mem_a  output  32  bus address
- mem_dout  output  8  bus write byte
- mem_wr  output  1  bus write strobe
- io_buffer_full  input  1  UART buffer full
- q_count  output  PTR_W+1  current number of queued entries

Behaviour:
- Clock and reset: one clock, clk_in; rst_in is synchronous and active-high.
- Reset: queue empty, head/tail/q_count = 0, no drain in progress. Outputs follow the mux with an empty queue: mem_wr=0, mem_a=cpu_a when cpu_req=1 (else 0), mem_dout=0 unless passing through, cpu_stall=0.
- rdy_in low: no pointer or state update, mem_wr forced 0, cpu_stall=1.
- Request classification (combinational), with is_io = cpu_a[17:16]==2'b11:
  - RAM access: cpu_req & !is_io.
  - IO write: cpu_req & is_io & cpu_wr.
  - IO read: cpu_req & is_io & !cpu_wr.
- Bus mux, priority in this order:
  1. RAM access: drive cpu_a/cpu_dout/cpu_wr onto the bus; cpu_stall=0; queue does not drain this cycle.
  2. IO read with q_count==0: pass through, cpu_stall=0.
  3. IO read with q_count>0: cpu_stall=1.
  4. IO write with q_count==0 and io_buffer_full==0: pass through (mem_wr=1), no enqueue.
  5. IO write otherwise: enqueue {cpu_a[17:0], cpu_dout} at tail if not full, cpu_stall=0. If full, cpu_stall=1 and nothing is written.
- Drain: a bus slot is free when there is no RAM access, no IO read pass-through and no IO write pass-through. In a free slot, if q_count>0 and io_buffer_full==0, drive the head entry (mem_a zero-extended from 18 bits, mem_wr=1) and advance head.
- Simultaneous enqueue and drain in the same cycle: q_count is unchanged. A full queue may accept a new write in a cycle where it also drains, because full is evaluated after the drain. cpu_stall is therefore low when q_count==DEPTH and a drain occurs.
- Pointers wrap modulo DEPTH. q_count ranges 0..DEPTH, and the full and empty conditions derive from q_count.
- Idle (no cpu_req, no drain): mem_wr=0, mem_a=0, mem_dout=0.
- Writes to 0x30004 (halt) are handled like any other I/O write: queued and ordered behind earlier UART bytes.
- Reset mid-operation: queued entries are discarded; no partial write is issued in the reset cycle.
- io_buffer_full sampled combinationally in the cycle of issue. No write with mem_wr=1 to an I/O address is ever driven while io_buffer_full=1.

Test Plan:
- Reset, then IO write 0x30000<-0x41 with io_buffer_full=0 -> same-cycle mem_wr=1, mem_a=0x30000, mem_dout=0x41, q_count stays 0.
- io_buffer_full=1, IO writes 0x41,0x42,0x43,0x44,0x45 on consecutive cycles -> first four accepted (q_count 1..4), fifth sees cpu_stall=1. Drop io_buffer_full -> bus emits 0x41,0x42,0x43,0x44 in order on idle cycles, then the fifth is accepted.
- Queue holds 2 entries, io_buffer_full=0, core issues RAM read 0x00100 every cycle for 3 cycles -> RAM reads pass, q_count stays 2. Core goes idle -> 2 drains in the next 2 cycles.
- Queue holds 1 entry, IO read 0x30004 requested -> cpu_stall=1 until the entry drains; next cycle the read passes with mem_wr=0, mem_a=0x30004.
- Queue full (4), io_buffer_full=0, IO write 0x46 in an idle-bus cycle -> head drains and 0x46 is enqueued in the same cycle, cpu_stall=0, q_count=4. Pointer wrap verified after 8 total entries.
- rdy_in=0 for 3 cycles with 2 queued and io_buffer_full=0 -> no mem_wr, q_count stays 2. Assert rst_in with 3 queued -> q_count=0 next cycle, no write issued.
